// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM: field widths,
// state encodings, ALU operation codes, opcode/funct constants, datapath
// select codes and the packed control word driven by the FSM each cycle.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W  = 6;  // opcode field width
  localparam int unsigned FN_W  = 6;  // funct field width
  localparam int unsigned ST_W  = 4;  // state register width
  localparam int unsigned ALU_W = 3;  // ALU control width
  localparam int unsigned SEL_W = 2;  // ALUSrcB / PCSource select width

  // FSM states; 13..15 are unused and recover to IDLE
  typedef enum logic [ST_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_e;

  // ALU operation codes understood by the datapath ALU
  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_MUL = 3'd3,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_ctrl_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [FN_W-1:0] FN_MUL = 6'h18;
  localparam logic [FN_W-1:0] FN_ADD = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB = 6'h22;
  localparam logic [FN_W-1:0] FN_AND = 6'h24;
  localparam logic [FN_W-1:0] FN_OR  = 6'h25;
  localparam logic [FN_W-1:0] FN_SLT = 6'h2A;

  // ALU B operand select
  localparam logic [SEL_W-1:0] SRCB_REGB    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  // Per-cycle datapath control word
  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] pc_source;
    alu_ctrl_e        alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath interface of the multi-cycle CPU.
// master: the control FSM (receives start, IR fields and the zero flag,
//         drives PC/memory/register-file enables, operand selects, ALU op).
// slave : the datapath side (the reverse directions).
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic             start_i;
  logic [OP_W-1:0]  Op_i;
  logic [FN_W-1:0]  Funct_i;
  logic             Zero_i;

  logic             PCEn_o;
  logic             IorD_o;
  logic             MemRead_o;
  logic             MemWrite_o;
  logic             IRWrite_o;
  logic             MemtoReg_o;
  logic             RegDst_o;
  logic             RegWrite_o;
  logic             ALUSrcA_o;
  logic [SEL_W-1:0] ALUSrcB_o;
  logic [SEL_W-1:0] PCSource_o;
  logic [ALU_W-1:0] ALUCtrl_o;
  logic [ST_W-1:0]  State_o;

  modport master (
    input  start_i, Op_i, Funct_i, Zero_i,
    output PCEn_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o,
           RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
           ALUCtrl_o, State_o
  );

  modport slave (
    output start_i, Op_i, Funct_i, Zero_i,
    input  PCEn_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o,
           RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
           ALUCtrl_o, State_o
  );

endinterface

// File: rtl/multicycle_ctrl_alu_funct_dec.sv
// R-type funct decoder: maps the IR funct field to an ALU operation and
// flags whether the funct is one the datapath supports.
// Ports:
//   funct_i       - IR funct field
//   alu_ctrl_c    - ALU operation (Add for unsupported functs)
//   funct_valid_c - 1 when funct_i is a supported R-type operation
module multicycle_ctrl_alu_funct_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [FN_W-1:0] funct_i,
  output alu_ctrl_e       alu_ctrl_c,
  output logic            funct_valid_c
);

  // Funct to ALU operation lookup
  always_comb begin
    alu_ctrl_c    = ALU_ADD;
    funct_valid_c = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_c = ALU_ADD;
      FN_SUB:  alu_ctrl_c = ALU_SUB;
      FN_AND:  alu_ctrl_c = ALU_AND;
      FN_OR:   alu_ctrl_c = ALU_OR;
      FN_SLT:  alu_ctrl_c = ALU_SLT;
      FN_MUL:  alu_ctrl_c = ALU_MUL;
      default: funct_valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM of the multi-cycle CPU. Walks each instruction through
// fetch, decode, execute, memory and writeback states and issues the
// datapath enables, operand selects and ALU operation for each step.
// Outputs are decoded from the registered state; the only combinational
// input paths are ALUCtrl_o in EXEC (from Funct_i) and PCEn_o in BRANCH
// (from Zero_i).
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous reset, active-low; forces IDLE
//   ctrl   - control/datapath interface (master side): start_i, Op_i,
//            Funct_i, Zero_i in; PCEn_o, IorD_o, MemRead_o, MemWrite_o,
//            IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
//            ALUSrcB_o, PCSource_o, ALUCtrl_o, State_o out
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master ctrl
);

  state_e    state_q;
  state_e    state_d;
  ctrl_t     ctl_c;
  alu_ctrl_e funct_alu_c;
  logic      funct_valid_c;

  multicycle_ctrl_alu_funct_dec u_alu_funct_dec (
    .funct_i       (ctrl.Funct_i),
    .alu_ctrl_c    (funct_alu_c),
    .funct_valid_c (funct_valid_c)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state control word
  always_comb begin
    state_d        = state_q;
    ctl_c          = '0;
    ctl_c.alu_ctrl = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (ctrl.start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        ctl_c.mem_read  = 1'b1;
        ctl_c.ir_write  = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.pc_source = PCSRC_ALU;
        ctl_c.pc_write  = 1'b1;
        state_d         = S_DECODE;
      end

      // ALU precomputes the branch target while the opcode is dispatched
      S_DECODE: begin
        ctl_c.alu_src_b = SRCB_IMM_SH2;
        case (ctrl.Op_i)
          OP_RTYPE:     state_d = funct_valid_c ? S_EXEC : S_FETCH;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_FETCH;
        endcase
      end

      S_MEMADR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        state_d         = (ctrl.Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        ctl_c.mem_read = 1'b1;
        ctl_c.iord     = 1'b1;
        state_d        = S_MEMWB;
      end

      S_MEMWB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 1'b1;
        state_d          = S_FETCH;
      end

      S_MEMWR: begin
        ctl_c.mem_write = 1'b1;
        ctl_c.iord      = 1'b1;
        state_d         = S_FETCH;
      end

      S_EXEC: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_REGB;
        ctl_c.alu_ctrl  = funct_alu_c;
        state_d         = S_RWB;
      end

      S_RWB: begin
        ctl_c.reg_write = 1'b1;
        ctl_c.reg_dst   = 1'b1;
        state_d         = S_FETCH;
      end

      S_BRANCH: begin
        ctl_c.alu_src_a     = 1'b1;
        ctl_c.alu_src_b     = SRCB_REGB;
        ctl_c.alu_ctrl      = ALU_SUB;
        ctl_c.pc_write_cond = 1'b1;
        ctl_c.pc_source     = PCSRC_ALUOUT;
        state_d             = S_FETCH;
      end

      S_JUMP: begin
        ctl_c.pc_write  = 1'b1;
        ctl_c.pc_source = PCSRC_JUMP;
        state_d         = S_FETCH;
      end

      S_IEXEC: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        state_d         = S_IWB;
      end

      S_IWB: begin
        ctl_c.reg_write = 1'b1;
        state_d         = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Zero only matters while pc_write_cond is set, i.e. in BRANCH
  assign ctrl.PCEn_o     = ctl_c.pc_write | (ctl_c.pc_write_cond & ctrl.Zero_i);
  assign ctrl.IorD_o     = ctl_c.iord;
  assign ctrl.MemRead_o  = ctl_c.mem_read;
  assign ctrl.MemWrite_o = ctl_c.mem_write;
  assign ctrl.IRWrite_o  = ctl_c.ir_write;
  assign ctrl.MemtoReg_o = ctl_c.mem_to_reg;
  assign ctrl.RegDst_o   = ctl_c.reg_dst;
  assign ctrl.RegWrite_o = ctl_c.reg_write;
  assign ctrl.ALUSrcA_o  = ctl_c.alu_src_a;
  assign ctrl.ALUSrcB_o  = ctl_c.alu_src_b;
  assign ctrl.PCSource_o = ctl_c.pc_source;
  assign ctrl.ALUCtrl_o  = ALU_W'(ctl_c.alu_ctrl);
  assign ctrl.State_o    = ST_W'(state_q);

endmodule
